// File: rtl/fib_stream_gen.sv
// fib_stream_gen: generalised Fibonacci-class sequence generator.
//
// Produces t[0]=seed_a, t[1]=seed_b, t[k]=t[k-1]+t[k-2] and streams the terms
// over a valid/ready handshake. On overflow it either stops before the first
// out-of-range term (OVF_MODE=0) or wraps modulo 2^WIDTH and carries on
// (OVF_MODE=1).
//
// Ports:
//   clk      in   clock, all state on the rising edge
//   rst      in   asynchronous active-low reset
//   start    in   one-cycle request to begin a sequence (ignored while busy)
//   seed_a   in   term 0, sampled on accepted start
//   seed_b   in   term 1, sampled on accepted start
//   n_terms  in   number of terms to emit, clamped to MAX_TERMS
//   f_ready  in   downstream accepts the current term
//   f_valid  out  f_out/f_idx hold a valid term
//   f_out    out  current term
//   f_idx    out  0-based index of the current term
//   busy     out  sequence in progress
//   done     out  one-cycle pulse when a sequence ends
//   ovf      out  sticky overflow flag, cleared on the next accepted start
module fib_stream_gen #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_TERMS = 1024,
    parameter int unsigned OVF_MODE  = 0,
    localparam int unsigned IW       = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic [IW-1:0]    n_terms,
    input  logic             f_ready,
    output logic             f_valid,
    output logic [WIDTH-1:0] f_out,
    output logic [IW-1:0]    f_idx,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam logic [0:0]    StIdle    = 1'b0;
    localparam logic [0:0]    StRun     = 1'b1;
    localparam logic [IW-1:0] MaxN      = IW'(MAX_TERMS);
    localparam bit            StopOnOvf = (OVF_MODE == 0);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;          // term currently presented
    logic [WIDTH-1:0] b_q, b_d;          // next term
    logic             b_bad_q, b_bad_d;  // b (or an earlier term) exceeded WIDTH bits
    logic [IW-1:0]    count_q, count_d;
    logic [IW-1:0]    n_lat_q, n_lat_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   sum;
    logic             carry;
    logic             xfer;
    logic             last_term;
    logic [IW-1:0]    n_clamped;

    assign sum       = {1'b0, a_q} + {1'b0, b_q};
    assign carry     = sum[WIDTH];
    assign xfer      = (state_q == StRun) && f_ready;
    assign last_term = (count_q == n_lat_q - 1'b1);
    assign n_clamped = (n_terms > MaxN) ? MaxN : n_terms;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        b_bad_d = b_bad_q;
        count_d = count_q;
        n_lat_d = n_lat_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (n_clamped != '0) begin
                        a_d     = seed_a;
                        b_d     = seed_b;
                        b_bad_d = 1'b0;
                        count_d = '0;
                        n_lat_d = n_clamped;
                        state_d = StRun;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                if (xfer) begin
                    // Count termination wins over overflow termination.
                    if (last_term) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (b_bad_q && StopOnOvf) begin
                        // The out-of-range term in b is never presented.
                        state_d = StIdle;
                        done_d  = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        a_d     = b_q;
                        b_d     = sum[WIDTH-1:0];
                        b_bad_d = b_bad_q | carry;
                        count_d = count_q + 1'b1;
                        if (!StopOnOvf && carry) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            b_bad_q <= 1'b0;
            count_q <= '0;
            n_lat_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            b_bad_q <= b_bad_d;
            count_q <= count_d;
            n_lat_q <= n_lat_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign f_valid = (state_q == StRun);
    assign busy    = (state_q == StRun);
    assign f_out   = a_q;
    assign f_idx   = count_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_fib_stream_gen.sv
module tb_fib_stream_gen;

    localparam int W    = 16;
    localparam int MAXT = 40;
    localparam int IW   = $clog2(MAXT + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          f_ready = 1'b0;
    logic [W-1:0]  seed_a = '0;
    logic [W-1:0]  seed_b = '0;
    logic [IW-1:0] n_terms = '0;

    // Index 0: stop-on-overflow instance, index 1: wrapping instance.
    logic          f_valid_w [2];
    logic          busy_w    [2];
    logic          done_w    [2];
    logic          ovf_w     [2];
    logic [W-1:0]  f_out_w   [2];
    logic [IW-1:0] f_idx_w   [2];

    always #5 clk = ~clk;

    fib_stream_gen #(.WIDTH(W), .MAX_TERMS(MAXT), .OVF_MODE(0)) u_stop (
        .clk(clk), .rst(rst), .start(start), .seed_a(seed_a), .seed_b(seed_b),
        .n_terms(n_terms), .f_ready(f_ready), .f_valid(f_valid_w[0]), .f_out(f_out_w[0]),
        .f_idx(f_idx_w[0]), .busy(busy_w[0]), .done(done_w[0]), .ovf(ovf_w[0])
    );

    fib_stream_gen #(.WIDTH(W), .MAX_TERMS(MAXT), .OVF_MODE(1)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .seed_a(seed_a), .seed_b(seed_b),
        .n_terms(n_terms), .f_ready(f_ready), .f_valid(f_valid_w[1]), .f_out(f_out_w[1]),
        .f_idx(f_idx_w[1]), .busy(busy_w[1]), .done(done_w[1]), .ovf(ovf_w[1])
    );

    int tests = 0;
    int fails = 0;

    // Reference model results.
    logic [W-1:0] exp_stop[$];
    logic [W-1:0] exp_wrap[$];
    bit           wrap_cum [MAXT+1];
    bit           mdl_ovf  [2];
    int           n_eff;

    // Per-instance scoreboard state.
    int            xfer_cnt   [2];
    bit            exp_done   [2];
    bit            fin        [2];
    bit            prev_stall [2];
    logic [W-1:0]  prev_out   [2];
    logic [IW-1:0] prev_idx   [2];
    logic [W-1:0]  last_out   [2];

    typedef struct {
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        int           n;
        int           mode;   // 0: always ready, 1: random ready, 2: 3-cycle stall at idx 4
        bit           bstart; // pulse a start while busy at idx 2
        int           len0;
        int           last0;
        bit           ovf0;
        int           len1;
        int           last1;
        bit           ovf1;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Plain-arithmetic sequence: carries tracked as a cumulative "true value
    // no longer fits" flag per term.
    task automatic build_model(input logic [W-1:0] sa, input logic [W-1:0] sb, input int n);
        longint t   [MAXT+1];
        bit     cum [MAXT+1];
        longint s;
        n_eff = (n > MAXT) ? MAXT : n;
        exp_stop.delete();
        exp_wrap.delete();
        mdl_ovf[0] = 1'b0;
        t[0] = sa;
        t[1] = sb;
        cum[0] = 1'b0;
        cum[1] = 1'b0;
        for (int j = 2; j <= MAXT; j++) begin
            s      = t[j-1] + t[j-2];
            cum[j] = cum[j-1] | (s >= 65536);
            t[j]   = s % 65536;
        end
        for (int k = 0; k < n_eff; k++) exp_wrap.push_back(W'(t[k]));
        for (int k = 0; k < n_eff; k++) begin
            if (k > 0 && cum[k]) begin
                mdl_ovf[0] = 1'b1;
                break;
            end
            exp_stop.push_back(W'(t[k]));
        end
        // Wrap mode sees the carries of every advancing transfer: terms 2..n.
        mdl_ovf[1] = (n_eff >= 2) && cum[n_eff];
        for (int j = 0; j <= MAXT; j++) wrap_cum[j] = cum[j];
    endtask

    task automatic check_cycle(input int d, input bit rdy);
        int sz;
        int adv;
        int k;
        sz = (d == 0) ? exp_stop.size() : exp_wrap.size();
        chk($sformatf("done[%0d]", d), done_w[d], exp_done[d]);
        if (exp_done[d]) fin[d] = 1'b1;
        exp_done[d] = 1'b0;
        chk($sformatf("busy_eq_valid[%0d]", d), busy_w[d], f_valid_w[d]);
        if (done_w[d]) chk($sformatf("done_excl_valid[%0d]", d), f_valid_w[d], 0);
        if (prev_stall[d]) begin
            chk($sformatf("hold_valid[%0d]", d), f_valid_w[d], 1);
            chk($sformatf("hold_out[%0d]", d), f_out_w[d], prev_out[d]);
            chk($sformatf("hold_idx[%0d]", d), f_idx_w[d], prev_idx[d]);
        end
        if (d == 1) begin
            adv = (xfer_cnt[1] < n_eff - 1) ? xfer_cnt[1] : n_eff - 1;
            chk("ovf_wrap_running", ovf_w[1], (adv >= 1) ? wrap_cum[adv+1] : 0);
        end
        if (f_valid_w[d] && rdy) begin
            k = xfer_cnt[d];
            if (k < sz) begin
                chk($sformatf("term[%0d] idx %0d", d, k), f_out_w[d],
                    (d == 0) ? exp_stop[k] : exp_wrap[k]);
                chk($sformatf("f_idx[%0d]", d), f_idx_w[d], k);
            end else begin
                chk($sformatf("extra_term[%0d]", d), k, sz);
            end
            last_out[d] = f_out_w[d];
            xfer_cnt[d]++;
            if (xfer_cnt[d] == sz) exp_done[d] = 1'b1;
        end
        prev_stall[d] = f_valid_w[d] && !rdy;
        prev_out[d]   = f_out_w[d];
        prev_idx[d]   = f_idx_w[d];
    endtask

    task automatic run_case(input vec_t v);
        bit rdy;
        bit injected;
        int stall_cnt;
        build_model(v.sa, v.sb, v.n);
        injected  = 1'b0;
        stall_cnt = 0;
        for (int d = 0; d < 2; d++) begin
            xfer_cnt[d]   = 0;
            fin[d]        = 1'b0;
            prev_stall[d] = 1'b0;
            exp_done[d]   = (n_eff == 0);
            last_out[d]   = '0;
        end
        @(negedge clk);
        seed_a  = v.sa;
        seed_b  = v.sb;
        n_terms = IW'(v.n);
        start   = 1'b1;
        f_ready = 1'b0;
        for (int c = 0; c < 400 && !(fin[0] && fin[1]); c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 0) begin
                chk("ovf_cleared_stop", ovf_w[0], 0);
                chk("ovf_cleared_wrap", ovf_w[1], 0);
            end
            if (v.bstart && !injected && f_valid_w[0] && f_idx_w[0] == 2) begin
                start    = 1'b1;
                seed_a   = 16'd0;
                seed_b   = 16'd1;
                n_terms  = IW'(7);
                injected = 1'b1;
            end
            case (v.mode)
                1:       rdy = ($urandom_range(0, 3) != 0);
                2: begin
                    rdy = 1'b1;
                    if (f_valid_w[0] && f_idx_w[0] == 4 && stall_cnt < 3) begin
                        rdy = 1'b0;
                        stall_cnt++;
                    end
                end
                default: rdy = 1'b1;
            endcase
            f_ready = rdy;
            check_cycle(0, rdy);
            check_cycle(1, rdy);
        end
        chk("finished_in_budget", fin[0] && fin[1], 1);
        @(negedge clk);
        f_ready = 1'b0;
        check_cycle(0, 1'b0);
        check_cycle(1, 1'b0);
        chk("len_stop", xfer_cnt[0], v.len0);
        chk("last_stop", last_out[0], v.last0);
        chk("ovf_stop", ovf_w[0], v.ovf0);
        chk("len_wrap", xfer_cnt[1], v.len1);
        chk("last_wrap", last_out[1], v.last1);
        chk("ovf_wrap", ovf_w[1], v.ovf1);
        chk("idle_stop", busy_w[0], 0);
        chk("idle_wrap", busy_w[1], 0);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{16'd0, 16'd1, 10, 0, 1'b0, 10, 34, 1'b0, 10, 34, 1'b0};
        tbl[1] = '{16'd0, 16'd1, 10, 2, 1'b0, 10, 34, 1'b0, 10, 34, 1'b0};
        tbl[2] = '{16'd0, 16'd1, 30, 0, 1'b0, 25, 46368, 1'b1, 30, 55477, 1'b1};
        tbl[3] = '{16'd0, 16'd1, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0};
        tbl[4] = '{16'd2, 16'd1, 5, 0, 1'b1, 5, 7, 1'b0, 5, 7, 1'b0};
        tbl[5] = '{16'd0, 16'd1, 0, 1, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0};
        tbl[6] = '{16'd0, 16'd1, 50, 1, 1'b0, 25, 46368, 1'b1, 40, 3746, 1'b1};
        tbl[7] = '{16'd65535, 16'd65535, 1, 0, 1'b0, 1, 65535, 1'b0, 1, 65535, 1'b0};
        tbl[8] = '{16'd65535, 16'd1, 2, 0, 1'b0, 2, 1, 1'b0, 2, 1, 1'b1};
        tbl[9] = '{16'd65535, 16'd1, 3, 1, 1'b0, 2, 1, 1'b1, 3, 0, 1'b1};

        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_valid[%0d]", d), f_valid_w[d], 0);
            chk($sformatf("reset_out[%0d]", d), f_out_w[d], 0);
            chk($sformatf("reset_busy[%0d]", d), busy_w[d], 0);
            chk($sformatf("reset_done[%0d]", d), done_w[d], 0);
            chk($sformatf("reset_ovf[%0d]", d), ovf_w[d], 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) run_case(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            v.sa     = W'($urandom);
            v.sb     = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : $urandom);
            v.n      = $urandom_range(0, 45);
            v.mode   = 1;
            v.bstart = ($urandom_range(0, 1) == 1);
            build_model(v.sa, v.sb, v.n);
            v.len0   = exp_stop.size();
            v.last0  = (exp_stop.size() > 0) ? int'(exp_stop[$]) : 0;
            v.ovf0   = mdl_ovf[0];
            v.len1   = exp_wrap.size();
            v.last1  = (exp_wrap.size() > 0) ? int'(exp_wrap[$]) : 0;
            v.ovf1   = mdl_ovf[1];
            run_case(v);
        end

        // Asynchronous reset mid-sequence: wrap instance has ovf=1, stop one
        // has already stopped with ovf=1, both hold nonzero terms.
        @(negedge clk);
        seed_a  = 16'd65535;
        seed_b  = 16'd65535;
        n_terms = IW'(20);
        start   = 1'b1;
        f_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && f_idx_w[1] != 6; c++) @(negedge clk);
        chk("reach_idx6", f_idx_w[1], 6);
        chk("pre_reset_ovf_wrap", ovf_w[1], 1);
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("async_valid[%0d]", d), f_valid_w[d], 0);
            chk($sformatf("async_out[%0d]", d), f_out_w[d], 0);
            chk($sformatf("async_idx[%0d]", d), f_idx_w[d], 0);
            chk($sformatf("async_busy[%0d]", d), busy_w[d], 0);
            chk($sformatf("async_done[%0d]", d), done_w[d], 0);
            chk($sformatf("async_ovf[%0d]", d), ovf_w[d], 0);
        end
        @(posedge clk);
        #1;
        chk("no_done_after_reset_stop", done_w[0], 0);
        chk("no_done_after_reset_wrap", done_w[1], 0);
        @(negedge clk);
        rst     = 1'b1;
        f_ready = 1'b0;
        run_case(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fib_stream_gen.md
Name: fib_stream_gen

Overview:
Parametrised Fibonacci-class sequence generator with programmable seeds, term count and overflow policy. It streams terms over a valid/ready handshake to downstream consumers. It also reports index, busy, done and overflow status. This is the successor of the team's fixed 16-bit, enable-driven generator, for datapaths that need backpressure and wider or generalised recurrences (Fibonacci, Lucas, any a,b seed pair).

Parameters:
WIDTH, 16, bit width of terms, seeds and f_out
MAX_TERMS, 1024, largest programmable term count; IW = $clog2(MAX_TERMS+1)
OVF_MODE, 0, 0 = stop on overflow, 1 = wrap modulo 2^WIDTH and continue

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  one-cycle request to begin a sequence; ignored while busy=1
seed_a  in  WIDTH  term 0, sampled on accepted start
seed_b  in  WIDTH  term 1, sampled on accepted start
n_terms  in  IW  number of terms to emit, sampled on accepted start; values > MAX_TERMS are clamped to MAX_TERMS
f_ready  in  1  downstream accepts the current term
f_valid  out  1  f_out/f_idx hold a valid term
f_out  out  WIDTH  current term
f_idx  out  IW  index of the current term, 0-based
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when a sequence ends (count reached or overflow stop)
ovf  out  1  sticky overflow flag, cleared on the next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. f_valid=0, f_out=0, f_idx=0, busy=0, done=0, ovf=0. Internal a=0, b=0, b_bad=0, count=0. Reset mid-sequence aborts immediately; no done pulse.
- Registers: a (presented term), b (next term), b_bad (b overflowed), count (IW bits), n_lat (latched n_terms).
- IDLE:
  - busy=0, f_valid=0.
  - start=1 with n_terms!=0: load a=seed_a, b=seed_b, b_bad=0, count=0, ovf=0; go to RUN. f_valid=1 on the cycle after the start edge (latency 1).
  - start=1 with n_terms==0: ovf cleared; done=1 for the next cycle; stay in IDLE; f_valid never asserts.
- RUN:
  - busy=1, f_valid=1, f_out=a, f_idx=count.
  - f_out and f_idx stay stable while f_ready=0 (no drop, no advance).
  - Transfer = f_valid&f_ready. On a transfer:
    - sum = a+b computed at WIDTH+1 bits; carry = sum[WIDTH].
    - If count==n_lat-1: go to IDLE, done=1 next cycle, f_valid=0.
    - Else if b_bad==1 and OVF_MODE==0: go to IDLE, done=1, ovf=1, f_valid=0. The invalid term is never presented.
    - Else: a<=b, b<=sum[WIDTH-1:0], b_bad<=b_bad|carry, count<=count+1.
    - When OVF_MODE==1 and carry=1, ovf<=1 and the block keeps running with wrapped values.
  - Count termination has priority over overflow termination when both apply on the same transfer (ovf then stays 0 in stop mode).
- start while busy=1: ignored, no effect on state or seeds.
- done is a registered single-cycle pulse; done and f_valid are never both 1.
- ovf holds its value after done until the next accepted start or reset.

Test Plan:
1. WIDTH=16, seeds 0/1, n_terms=10, f_ready=1 -> f_out 0,1,1,2,3,5,8,13,21,34 on consecutive cycles with f_idx 0..9; done pulse the cycle after idx 9; ovf=0; busy falls with done.
2. Same run with f_ready=0 for 3 cycles while f_idx=4 -> f_out=3 and f_idx=4 held for 4 cycles; remaining terms unchanged; total 10 transfers.
3. OVF_MODE=0, seeds 0/1, n_terms=30 -> 25 terms emitted, last one f_idx=24 f_out=46368; then done=1 and ovf=1; term 75025 never appears.
4. OVF_MODE=1, same stimulus -> f_idx=25 f_out=9489 (75025-65536); ovf=1 from the transfer of idx 23 onward; 30 terms emitted, then done.
5. Seeds 2/1 (Lucas), n_terms=5 -> 2,1,3,4,7. A start pulse with seeds 0/1 at idx 2 is ignored. A second start after done with n_terms=0 -> done pulse, f_valid stays 0.
6. rst=0 asserted asynchronously mid-clock at f_idx=6 -> all outputs 0 immediately, no done pulse. After release, start produces the sequence from idx 0.
